// File: rtl/mac_pkg.sv
// mac_pkg: shared state type and default widths/latency for the
// MAC sequencer and the MAC it drives.
package mac_pkg;

  localparam int MAC_DATA_WIDTH     = 8;
  localparam int MAC_LEN_WIDTH      = 8;
  localparam int MAC_PIPELINE_DELAY = 1;
  localparam int MAC_OUT_WIDTH      = 3 * MAC_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_OUT
  } mac_ctrl_state_t;

  function automatic int drain_width(input int delay);
    return (delay < 2) ? 1 : $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/mac_ctrl.sv
// mac_ctrl: per-job dot-product sequencer; joins the A/B operand
// streams into the MAC, waits out its latency, then offers Cout.
module mac_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH     = MAC_DATA_WIDTH,
  parameter int LEN_WIDTH      = MAC_LEN_WIDTH,
  parameter int PIPELINE_DELAY = MAC_PIPELINE_DELAY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic                    a_valid,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    b_ready,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_ain,
  output logic [DATA_WIDTH-1:0]   mac_bin,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  output logic [3*DATA_WIDTH-1:0] res_data,
  input  logic                    res_ready,
  output logic                    busy
);

  localparam int DCW = drain_width(PIPELINE_DELAY);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(PIPELINE_DELAY);
  localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  mac_ctrl_state_t       state;
  logic [LEN_WIDTH-1:0]  pair_cnt;
  logic [DCW-1:0]        drain_cnt;
  logic                  feed;
  logic                  fire;

  // Joint handshake: a pair is only taken when both sides are valid.
  assign feed      = (state == ST_FEED);
  assign fire      = feed && a_valid && b_valid;
  assign a_ready   = feed && b_valid;
  assign b_ready   = feed && a_valid;
  assign mac_en    = fire;
  assign mac_ain   = feed ? a_data : '0;
  assign mac_bin   = feed ? b_data : '0;
  assign mac_clr   = (state == ST_CLEAR);
  assign res_valid = (state == ST_OUT);
  assign res_data  = res_valid ? mac_cout : '0;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pair_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            pair_cnt <= len;
            state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          state <= (pair_cnt != '0) ? ST_FEED : ST_OUT;
        end
        ST_FEED: begin
          if (fire) begin
            pair_cnt <= pair_cnt - LEN_ONE;
            if (pair_cnt == LEN_ONE) begin
              drain_cnt <= DRAIN_LOAD;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - DRAIN_ONE;
          if (drain_cnt == DRAIN_ONE)
            state <= ST_OUT;
        end
        ST_OUT: begin
          if (res_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_ctrl.sv
// tb_mac_ctrl: drives jobs into mac_ctrl with a behavioural MAC and
// checks every cycle against a job-level model.
`timescale 1ns/1ps
module tb_mac_ctrl;
  import mac_pkg::*;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int PD = MAC_PIPELINE_DELAY;
  localparam int OW = 3 * DW;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic [LW-1:0] len = '0;
  logic          a_valid = 0;
  logic [DW-1:0] a_data = '0;
  logic          a_ready;
  logic          b_valid = 0;
  logic [DW-1:0] b_data = '0;
  logic          b_ready;
  logic          mac_en;
  logic          mac_clr;
  logic [DW-1:0] mac_ain;
  logic [DW-1:0] mac_bin;
  logic [OW-1:0] mac_cout;
  logic          res_valid;
  logic [OW-1:0] res_data;
  logic          res_ready = 0;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int last_wait = 0;
  int ja[$];
  int jb[$];

  always #5 clk = ~clk;

  mac_ctrl #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH(LW),
    .PIPELINE_DELAY(PD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_ain(mac_ain), .mac_bin(mac_bin), .mac_cout(mac_cout),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  // Behavioural MAC: accumulate, then PD-deep output delay
  logic [OW-1:0] acc;
  logic [OW-1:0] acc_nxt;
  logic [OW-1:0] pipe [PD];

  always_comb begin
    acc_nxt = acc;
    if (mac_clr) acc_nxt = '0;
    else if (mac_en) acc_nxt = acc + OW'(mac_ain) * OW'(mac_bin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      for (int i = 0; i < PD; i++) pipe[i] <= '0;
    end else begin
      acc <= acc_nxt;
      pipe[0] <= acc_nxt;
      for (int i = 1; i < PD; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign mac_cout = pipe[PD-1];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Job-level reference: phase, pairs left, cycles left, running sum
  localparam int P_IDLE = 0;
  localparam int P_CLR = 1;
  localparam int P_FEED = 2;
  localparam int P_DRAIN = 3;
  localparam int P_OUT = 4;

  int            m_phase = P_IDLE;
  int            m_rem = 0;
  int            m_left = 0;
  logic [OW-1:0] m_sum = '0;

  always @(negedge clk) begin
    bit fd;
    bit f;
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_rem = 0;
      m_left = 0;
      m_sum = '0;
    end
    fd = (m_phase == P_FEED);
    f = fd && a_valid && b_valid;
    chk("busy", busy, m_phase != P_IDLE);
    chk("mac_clr", mac_clr, m_phase == P_CLR);
    chk("mac_en", mac_en, f);
    chk("a_ready", a_ready, fd && b_valid);
    chk("b_ready", b_ready, fd && a_valid);
    chk("mac_ain", mac_ain, fd ? a_data : 8'd0);
    chk("mac_bin", mac_bin, fd ? b_data : 8'd0);
    chk("res_valid", res_valid, m_phase == P_OUT);
    chk("res_data", res_data, (m_phase == P_OUT) ? m_sum : 24'd0);
    if (rst_n) begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_rem = int'(len);
          m_sum = '0;
          m_phase = P_CLR;
        end
        P_CLR: m_phase = (m_rem == 0) ? P_OUT : P_FEED;
        P_FEED: if (f) begin
          m_sum = OW'(longint'(m_sum) + longint'(a_data) * longint'(b_data));
          m_rem--;
          if (m_rem == 0) begin
            m_left = PD;
            m_phase = P_DRAIN;
          end
        end
        P_DRAIN: begin
          m_left--;
          if (m_left == 0) m_phase = P_OUT;
        end
        default: if (res_ready) m_phase = P_IDLE;
      endcase
    end
  end

  task automatic do_start(input int n);
    start = 1;
    len = LW'(n);
    @(posedge clk); #1;
    start = 0;
    len = '0;
  endtask

  task automatic do_feed(input int n, input int mode);
    int idx = 0;
    int guard = 0;
    bit took;
    while (idx < n && guard < 5000) begin
      a_data = DW'(ja[idx]);
      b_data = DW'(jb[idx]);
      case (mode)
        0: begin a_valid = 1; b_valid = 1; end
        1: begin a_valid = 1; b_valid = guard[0]; end
        default: begin
          a_valid = ($urandom_range(0, 3) != 0);
          b_valid = ($urandom_range(0, 3) != 0);
          start = $urandom_range(0, 1);
          len = LW'($urandom);
        end
      endcase
      @(negedge clk);
      took = a_valid && a_ready && b_valid && b_ready;
      @(posedge clk); #1;
      if (took) idx++;
      guard++;
    end
    a_valid = 0;
    b_valid = 0;
    a_data = '0;
    b_data = '0;
    start = 0;
    len = '0;
    if (idx < n) chk("feed_timeout", idx, n);
  endtask

  task automatic do_result(input int hold, output logic [OW-1:0] r);
    int n = 0;
    res_ready = 0;
    while (!res_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    last_wait = n;
    if (!res_valid) begin
      chk("result_timeout", 0, 1);
      r = '0;
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    res_ready = 1;
    @(negedge clk);
    r = res_data;
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  task automatic run_job(input int n, input int mode, input int hold,
                         output logic [OW-1:0] r);
    do_start(n);
    do_feed(n, mode);
    do_result(hold, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] r;
    longint s;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_mac_clr", mac_clr, 0);
    rst_n = 1;
    @(posedge clk); #1;

    ja = '{1, 2, 3}; jb = '{4, 5, 6};
    run_job(3, 0, 0, r);
    chk("basic_sum", r, 32);
    chk("basic_latency", last_wait, PD);

    ja = '{2, 2, 2, 2}; jb = '{3, 3, 3, 3};
    run_job(4, 1, 0, r);
    chk("stall_sum", r, 24);

    ja.delete(); jb.delete();
    run_job(0, 0, 0, r);
    chk("len0_sum", r, 0);
    chk("len0_latency", last_wait, 1);

    ja = '{10, 20, 30}; jb = '{1, 2, 3};
    run_job(3, 0, 5, r);
    chk("hold_sum", r, 140);
    ja = '{255}; jb = '{255};
    run_job(1, 0, 0, r);
    chk("b2b_sum", r, 65025);

    ja.delete(); jb.delete();
    for (int i = 0; i < 255; i++) begin
      ja.push_back(255);
      jb.push_back(255);
    end
    run_job(255, 2, 1, r);
    chk("overflow_sum", r, 16581375);

    ja = '{9, 9, 9, 9, 9}; jb = '{9, 9, 9, 9, 9};
    do_start(5);
    do_feed(2, 0);
    rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mac_en", mac_en, 0);
    chk("midrst_a_ready", a_ready, 0);
    chk("midrst_res_valid", res_valid, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    ja = '{7}; jb = '{6};
    run_job(1, 0, 0, r);
    chk("post_rst_sum", r, 42);

    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 12);
      ja.delete(); jb.delete();
      s = 0;
      for (int i = 0; i < n; i++) begin
        ja.push_back($urandom_range(0, 255));
        jb.push_back($urandom_range(0, 255));
        s += longint'(ja[i]) * longint'(jb[i]);
      end
      run_job(n, $urandom_range(0, 2), $urandom_range(0, 3), r);
      chk("rand_sum", r, s & 64'hFF_FFFF);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
